// File: rtl/test_sequencer_pkg.sv
// Shared types and constants for the board self-test sequencer.
// Holds the FSM states, the LED gap length and the index-width sizing rule.
package test_sequencer_pkg;

  typedef enum logic [2:0] {
    S_DELAY,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_SAMPLE,
    S_DONE
  } seq_state_e;

  localparam int unsigned LED_GAP_TICKS = 4;

  function automatic bit idx_bits_ok(input int unsigned n_tests, input int unsigned idx_bits);
    return (n_tests >= 1) && (n_tests <= 16) && (idx_bits >= 1) && (idx_bits <= 8)
        && ((32'd1 << idx_bits) >= n_tests);
  endfunction

endpackage

// File: rtl/test_sequencer_if.sv
// Fixture handshake: one-hot run level out, busy and result flags back.
interface test_sequencer_if #(
  parameter int unsigned N_TESTS = 4
);
  logic [N_TESTS-1:0] run;
  logic [N_TESTS-1:0] running;
  logic [N_TESTS-1:0] passed;

  modport master (output run, input running, input passed);
  modport slave  (input run, output running, output passed);
endinterface

// File: rtl/test_sequencer_led_blink_code.sv
// Red blink code: (i_count+1) pulses of one tick on / one tick off, then a
// fixed gap of ticks; the pattern restarts from the first pulse whenever i_en rises.
module led_blink_code
  import test_sequencer_pkg::*;
#(
  parameter int unsigned IDX_BITS   = 2,
  parameter int unsigned BLINK_BITS = 22
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic [IDX_BITS-1:0] i_count,
  output logic                o_pulse
);

  logic [BLINK_BITS-1:0] tick_q;
  logic [IDX_BITS+1:0]   pulse_cnt_q;
  logic [1:0]            gap_cnt_q;
  logic                  in_gap_q;
  logic                  tick;
  logic [IDX_BITS+1:0]   last_slot;

  assign tick      = &tick_q;
  // Even slots are "on", odd slots "off"; the last slot index is 2*count+1.
  assign last_slot = {1'b0, i_count, 1'b1};

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      tick_q      <= '0;
      pulse_cnt_q <= '0;
      gap_cnt_q   <= '0;
      in_gap_q    <= 1'b0;
    end else begin
      tick_q <= tick_q + 1'b1;
      if (tick) begin
        if (!in_gap_q) begin
          if (pulse_cnt_q == last_slot) begin
            pulse_cnt_q <= '0;
            in_gap_q    <= 1'b1;
          end else begin
            pulse_cnt_q <= pulse_cnt_q + 1'b1;
          end
        end else if (gap_cnt_q == 2'(LED_GAP_TICKS - 1)) begin
          gap_cnt_q <= '0;
          in_gap_q  <= 1'b0;
        end else begin
          gap_cnt_q <= gap_cnt_q + 1'b1;
        end
      end
    end
  end

  assign o_pulse = i_en & ~in_gap_q & ~pulse_cnt_q[0];

endmodule

// File: rtl/test_sequencer.sv
// Board self-test sequencer: start-up delay, then runs each fixture in turn with
// a per-phase watchdog, aggregates results and reports them on the RGB LED.
module test_sequencer
  import test_sequencer_pkg::*;
#(
  parameter int unsigned N_TESTS      = 4,
  parameter int unsigned IDX_BITS     = 2,
  parameter int unsigned DELAY_BITS   = 6,
  parameter int unsigned TIMEOUT_BITS = 16,
  parameter int unsigned BLINK_BITS   = 22,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  test_sequencer_if.master    fx,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [N_TESTS-1:0]  o_fail_mask,
  output logic                o_timeout,
  output logic [IDX_BITS-1:0] o_fail_idx,
  output logic                o_led_r,
  output logic                o_led_g,
  output logic                o_led_b
);

  if (!idx_bits_ok(N_TESTS, IDX_BITS)) begin : g_bad_cfg
    $error("test_sequencer: need 1 <= N_TESTS <= 16 and 2**IDX_BITS >= N_TESTS");
  end

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_TESTS - 1);
  localparam logic [N_TESTS-1:0]  RUN0     = N_TESTS'(1);

  seq_state_e              state_q;
  logic [DELAY_BITS-1:0]   dly_q;
  logic [IDX_BITS-1:0]     k_q;
  logic [TIMEOUT_BITS:0]   wd_q;
  logic [TIMEOUT_BITS:0]   wd_d;
  logic [N_TESTS-1:0]      run_q;
  logic [N_TESTS-1:0]      fail_mask_q;
  logic [IDX_BITS-1:0]     fail_idx_q;
  logic                    busy_q, done_q, pass_q, timeout_q, cur_fail_q, active_q;
  logic                    first_fail;
  logic                    show_code, pulse;

  assign wd_d       = wd_q + 1'b1;
  assign first_fail = (fail_mask_q == '0);

  // o_run is loaded on the transition into START and cleared on the transition
  // into SAMPLE, so it is visible for START..WAIT_LO and low during SAMPLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_DELAY;
      dly_q       <= '0;
      k_q         <= '0;
      wd_q        <= '0;
      run_q       <= '0;
      fail_mask_q <= '0;
      fail_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cur_fail_q  <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      case (state_q)
        S_DELAY: begin
          active_q <= 1'b1;
          dly_q    <= dly_q + 1'b1;
          if (&dly_q) begin
            state_q    <= S_START;
            k_q        <= '0;
            busy_q     <= 1'b1;
            run_q      <= RUN0;
            cur_fail_q <= 1'b0;
            wd_q       <= '0;
          end
        end
        S_START: begin
          wd_q    <= '0;
          state_q <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (fx.running[k_q]) begin
            wd_q    <= '0;
            state_q <= S_WAIT_LO;
          end else if (wd_d[TIMEOUT_BITS]) begin
            fail_mask_q[k_q] <= 1'b1;
            if (first_fail) fail_idx_q <= k_q;
            timeout_q  <= 1'b1;
            cur_fail_q <= 1'b1;
            run_q      <= '0;
            wd_q       <= '0;
            state_q    <= S_SAMPLE;
          end else begin
            wd_q <= wd_d;
          end
        end
        S_WAIT_LO: begin
          if (!fx.running[k_q]) begin
            if (!fx.passed[k_q]) begin
              fail_mask_q[k_q] <= 1'b1;
              if (first_fail) fail_idx_q <= k_q;
            end
            cur_fail_q <= ~fx.passed[k_q];
            run_q      <= '0;
            wd_q       <= '0;
            state_q    <= S_SAMPLE;
          end else if (wd_d[TIMEOUT_BITS]) begin
            fail_mask_q[k_q] <= 1'b1;
            if (first_fail) fail_idx_q <= k_q;
            timeout_q  <= 1'b1;
            cur_fail_q <= 1'b1;
            run_q      <= '0;
            wd_q       <= '0;
            state_q    <= S_SAMPLE;
          end else begin
            wd_q <= wd_d;
          end
        end
        S_SAMPLE: begin
          wd_q <= '0;
          if ((STOP_ON_FAIL && cur_fail_q) || (k_q == LAST_IDX)) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            pass_q   <= first_fail;
            active_q <= 1'b0;
            state_q  <= S_DONE;
          end else begin
            k_q        <= k_q + 1'b1;
            run_q      <= RUN0 << (k_q + 1'b1);
            cur_fail_q <= 1'b0;
            state_q    <= S_START;
          end
        end
        S_DONE: state_q <= S_DONE;
        default: state_q <= S_DELAY;
      endcase
    end
  end

  assign show_code = done_q & ~pass_q;

  led_blink_code #(
    .IDX_BITS   (IDX_BITS),
    .BLINK_BITS (BLINK_BITS)
  ) u_blink (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (show_code),
    .i_count (fail_idx_q),
    .o_pulse (pulse)
  );

  assign fx.run      = run_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_fail_mask = fail_mask_q;
  assign o_timeout   = timeout_q;
  assign o_fail_idx  = fail_idx_q;
  assign o_led_g     = done_q & pass_q;
  assign o_led_r     = show_code & pulse;
  assign o_led_b     = active_q | (show_code & timeout_q & pulse);

endmodule
